// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the committed-store buffer.
package store_buffer_pkg;

   localparam int REGISTER_SIZE = 32;
   localparam int ADDRESS_SIZE  = 32;
   localparam int SB_ID_SIZE    = 2;
   localparam int SB_DEPTH      = 1 << SB_ID_SIZE;

   typedef logic [SB_ID_SIZE-1:0] sb_id_t;

   typedef struct packed {
      logic [ADDRESS_SIZE-1:0]  address;
      logic [REGISTER_SIZE-1:0] data;
      logic                     valid;
   } sb_entry_t;

   // Age of slot idx relative to the oldest slot; the SB_ID_SIZE-bit
   // result wraps naturally, so larger means younger.
   function automatic sb_id_t ring_dist(input sb_id_t idx, input sb_id_t head);
      return idx - head;
   endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of ROB commit, data-cache write and load-forwarding signals.
interface store_buffer_if;
   import store_buffer_pkg::*;

   logic [ADDRESS_SIZE-1:0]  store_address;
   logic [REGISTER_SIZE-1:0] store_data;
   logic                     store_req;
   logic                     store_stall;
   logic [ADDRESS_SIZE-1:0]  dc_address;
   logic [REGISTER_SIZE-1:0] dc_data;
   logic                     dc_req;
   logic                     dc_stall;
   logic [ADDRESS_SIZE-1:0]  ld_address;
   logic                     ld_hit;
   logic [REGISTER_SIZE-1:0] ld_data;
   logic                     sb_empty;

   // Environment side: ROB, cache and load unit.
   modport master (
      output store_address, store_data, store_req, dc_stall, ld_address,
      input  store_stall, dc_address, dc_data, dc_req, ld_hit, ld_data, sb_empty
   );

   // Store buffer side.
   modport slave (
      input  store_address, store_data, store_req, dc_stall, ld_address,
      output store_stall, dc_address, dc_data, dc_req, ld_hit, ld_data, sb_empty
   );

endinterface

// File: rtl/store_buffer_sb_forward.sv
// Combinational load forwarding: match every valid entry, youngest wins.
module sb_forward
   import store_buffer_pkg::*;
(
   input  sb_entry_t                entries_i [SB_DEPTH],
   input  sb_id_t                   head_i,
   input  logic [ADDRESS_SIZE-1:0]  ld_address_i,
   output logic                     ld_hit_o,
   output logic [REGISTER_SIZE-1:0] ld_data_o
);

   logic [SB_DEPTH-1:0] match;
   sb_id_t              age [SB_DEPTH];
   sb_id_t              best_age;

   generate
      for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_cmp
         assign match[gi] = entries_i[gi].valid && (entries_i[gi].address == ld_address_i);
         assign age[gi]   = ring_dist(sb_id_t'(gi), head_i);
      end
   endgenerate

   // Pick the matching entry with the largest distance from head.
   always_comb begin
      ld_hit_o  = 1'b0;
      ld_data_o = '0;
      best_age  = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (match[sb_id_t'(i)] && (!ld_hit_o || (age[sb_id_t'(i)] > best_age))) begin
            ld_hit_o  = 1'b1;
            best_age  = age[sb_id_t'(i)];
            ld_data_o = entries_i[sb_id_t'(i)].data;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO: accepts retired stores, drains them in order to
// the data cache and forwards buffered data to younger loads.
module store_buffer
   import store_buffer_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   store_buffer_if.slave sb
);

   localparam logic [SB_ID_SIZE:0] CNT_FULL = (SB_ID_SIZE+1)'(SB_DEPTH);
   localparam logic [SB_ID_SIZE:0] CNT_ONE  = (SB_ID_SIZE+1)'(1);
   localparam sb_id_t              PTR_ONE  = sb_id_t'(1);

   sb_entry_t           entry_q [SB_DEPTH];
   sb_id_t              head_q, head_d;
   sb_id_t              tail_q, tail_d;
   logic [SB_ID_SIZE:0] count_q, count_d;
   logic                empty, full, enq, deq;
   logic [SB_DEPTH-1:0] wr_en, clr_en;

   // Full/empty come only from the registered count, so a same-cycle
   // drain never admits a store into a full buffer.
   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_FULL);
   assign enq   = sb.store_req && !full;
   assign deq   = !empty && !sb.dc_stall;

   assign sb.store_stall = full;
   assign sb.sb_empty    = empty;
   assign sb.dc_req      = !empty;
   assign sb.dc_address  = empty ? '0 : entry_q[head_q].address;
   assign sb.dc_data     = empty ? '0 : entry_q[head_q].data;

   generate
      for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_slot
         assign wr_en[gi]  = enq && (tail_q == sb_id_t'(gi));
         assign clr_en[gi] = deq && (head_q == sb_id_t'(gi));
      end
   endgenerate

   // Next pointers and occupancy; enqueue plus drain leaves count unchanged.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (enq) tail_d = tail_q + PTR_ONE;
      if (deq) head_d = head_q + PTR_ONE;
      case ({enq, deq})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage: write at tail on enqueue, invalidate head on drain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SB_DEPTH; i++) entry_q[sb_id_t'(i)] <= '0;
      end else begin
         for (int i = 0; i < SB_DEPTH; i++) begin
            if (wr_en[sb_id_t'(i)]) begin
               entry_q[sb_id_t'(i)] <= '{address: sb.store_address,
                                         data:    sb.store_data,
                                         valid:   1'b1};
            end else if (clr_en[sb_id_t'(i)]) begin
               entry_q[sb_id_t'(i)].valid <= 1'b0;
            end
         end
      end
   end

   sb_forward u_fwd (
      .entries_i    (entry_q),
      .head_i       (head_q),
      .ld_address_i (sb.ld_address),
      .ld_hit_o     (sb.ld_hit),
      .ld_data_o    (sb.ld_data)
   );

endmodule
